// File: rtl/mmio_ram_pkg.sv
// mmio_ram_pkg: FSM state type and default address map for the MMIO RAM controller
package mmio_ram_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam int LED_ADDR_DEF = 128;
    localparam int SW_ADDR_DEF  = 129;
    localparam int SEG_ADDR_DEF = 192;
endpackage

// File: rtl/mmio_ram_if.sv
// mmio_ram_if: request/response bus between a master and the MMIO RAM controller
interface mmio_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              wrt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              busy;
    modport master (output req, wrt, addr, wdata, input rdata, done, err, busy);
    modport slave  (input req, wrt, addr, wdata, output rdata, done, err, busy);
endinterface

// File: rtl/mmio_ram_core.sv
// mmio_ram_core: single-port synchronous write-first RAM, contents are never reset
module mmio_ram_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                q         <= wdata;
            end else begin
                q <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/mmio_ram_ctrl.sv
// mmio_ram_ctrl: 3-cycle MMIO controller over a RAM with LED, switch and 7-seg registers.
// Define MMIO_RAM_SW_SYNC_EN to pass switches through a 2-flop synchronizer.
module mmio_ram_ctrl
    import mmio_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int LED_W    = 18,
    parameter int SW_W     = 18,
    parameter int LED_ADDR = LED_ADDR_DEF,
    parameter int SW_ADDR  = SW_ADDR_DEF,
    parameter int SEG_ADDR = SEG_ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mmio_ram_if.slave        bus,
    input  logic [SW_W-1:0]  switches,
    output logic [LED_W-1:0] led,
    output logic [DATA_W-1:0] seg
);
    state_t            state, state_nxt;
    logic              wrt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, ram_q;
    logic [SW_W-1:0]   sw_use;
    logic              is_sw, is_led, is_seg, ram_en, ram_we, ram_rd_done;

`ifdef MMIO_RAM_SW_SYNC_EN
    logic [SW_W-1:0] sw_meta, sw_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end
    assign sw_use = sw_sync;
`else
    assign sw_use = switches;
`endif

    assign is_sw  = addr_q == ADDR_W'(SW_ADDR);
    assign is_led = addr_q == ADDR_W'(LED_ADDR);
    assign is_seg = addr_q == ADDR_W'(SEG_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE   ? (bus.req ? ACCESS : IDLE) :
                    state == ACCESS ? DONE : IDLE;
    end

    // RAM read data lands during DONE and is latched into rdata_q on the way out
    always_comb begin
        ram_en      = state == ACCESS && !(wrt_q && is_sw);
        ram_we      = ram_en && wrt_q;
        ram_rd_done = state == DONE && !wrt_q && !is_sw;
        bus.done    = state == DONE;
        bus.busy    = state != IDLE;
        bus.err     = state == DONE && wrt_q && is_sw;
        bus.rdata   = ram_rd_done ? ram_q : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            led     <= '0;
            seg     <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                wrt_q   <= bus.wrt;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (state == ACCESS && wrt_q && is_led) led <= wdata_q[LED_W-1:0];
            if (state == ACCESS && wrt_q && is_seg) seg <= wdata_q;
            if (state == ACCESS && !wrt_q && is_sw) rdata_q <= DATA_W'(sw_use);
            if (ram_rd_done) rdata_q <= ram_q;
        end
    end

    mmio_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .q    (ram_q)
    );
endmodule
